// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter. It accepts signed or unsigned input
// and does one shift per clock, so a conversion takes WIDTH cycles in SHIFT.

module binary_to_bcd_digit (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

module binary_to_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [WIDTH-1:0]      binary_input,
  output logic [4*DIGITS-1:0]   bcd_output,
  output logic                  negative,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       mag_q, mag_d;
  logic [4*DIGITS-1:0]    scratch_q, scratch_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sign_q, sign_d;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d;
  logic                   neg_q, neg_d;

  logic [DIGITS-1:0][3:0] scratch_adj;
  logic                   neg_in;
  logic [WIDTH-1:0]       mag_in;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      binary_to_bcd_digit u_adj (
        .d_i (scratch_q[4*g +: 4]),
        .d_o (scratch_adj[g])
      );
    end
  endgenerate

  // Negating -2^(WIDTH-1) wraps back to itself, which is the correct unsigned magnitude.
  assign neg_in = is_signed & binary_input[WIDTH-1];
  assign mag_in = neg_in ? -binary_input : binary_input;

  always_comb begin
    logic [4*DIGITS+WIDTH-1:0] cat;
    state_d   = state_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    cat       = {scratch_adj, mag_q} << 1;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mag_d     = mag_in;
          sign_d    = neg_in;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          state_d   = SHIFT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        scratch_d = cat[4*DIGITS+WIDTH-1:WIDTH];
        mag_d     = cat[WIDTH-1:0];
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          bcd_d   = cat[4*DIGITS+WIDTH-1:WIDTH];
          neg_d   = sign_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
    end
  end

  assign bcd_output = bcd_q;
  assign negative   = neg_q;
  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
endmodule
